// File: rtl/mcb_avl_mport.sv
// mcb_avl_mport: NPORT-way Avalon-MM slave-port arbiter in front of one MCB
// Avalon master port.
//
// Arbitration: round-robin from (last_gnt+1) by default. Define
// MCB_AVL_MPORT_PRIO_EN for fixed priority (lowest index wins). In that mode
// a granted read that is blocked by a full tag FIFO parks in RWAIT.
//
// Ports
//   csi_clockreset_clk / csi_clockreset_reset : clock, sync active-high reset
//   avs_sN_*        : packed per-port slave requests (port p = slice p),
//                     per-port waitrequest/readdatavalid, shared readdata
//   avm_m1_*        : master toward the MCB Avalon wrapper
//   err_orphan      : sticky, read data arrived with no outstanding read
module mcb_avl_mport #(
    parameter int unsigned NPORT     = 2,
    parameter int unsigned AVL_A_W   = 22,
    parameter int unsigned AVL_D_W   = 32,
    parameter int unsigned BC_W      = 4,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                           csi_clockreset_clk,
    input  logic                           csi_clockreset_reset,
    input  logic [NPORT*AVL_A_W-1:0]       avs_sN_address,
    input  logic [NPORT-1:0]               avs_sN_read,
    input  logic [NPORT-1:0]               avs_sN_write,
    input  logic [NPORT*BC_W-1:0]          avs_sN_burstcount,
    input  logic [NPORT*(AVL_D_W/8)-1:0]   avs_sN_byteenable,
    input  logic [NPORT*AVL_D_W-1:0]       avs_sN_writedata,
    output logic [NPORT-1:0]               avs_sN_waitrequest,
    output logic [NPORT-1:0]               avs_sN_readdatavalid,
    output logic [AVL_D_W-1:0]             avs_sN_readdata,
    output logic [AVL_A_W-1:0]             avm_m1_address,
    output logic                           avm_m1_read,
    output logic                           avm_m1_write,
    output logic [BC_W-1:0]                avm_m1_burstcount,
    output logic [AVL_D_W/8-1:0]           avm_m1_byteenable,
    output logic [AVL_D_W-1:0]             avm_m1_writedata,
    input  logic                           avm_m1_waitrequest,
    input  logic                           avm_m1_readdatavalid,
    input  logic [AVL_D_W-1:0]             avm_m1_readdata,
    output logic                           err_orphan
);

    localparam int unsigned AVL_BE_W = AVL_D_W / 8;
    localparam int unsigned PW       = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned TW       = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CW       = TW + 1;

    typedef enum logic [1:0] {IDLE, WBURST, RWAIT} state_e;

    state_e          state_q;
    logic [PW-1:0]   gnt_q, last_gnt_q;
    logic [BC_W-1:0] wbeat_q, wlen_q, rbeat_q;
    logic [PW-1:0]   tag_port_q [TAG_DEPTH];
    logic [BC_W-1:0] tag_len_q  [TAG_DEPTH];
    logic [TW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            blk_q, err_q;

    logic            gate, full, empty, win_vld, mreq, acc;
    logic            cur_wr, cur_rd, push, pop, rvld, rlast;
    logic [NPORT-1:0] req;
    logic [PW-1:0]   win, cur, head_port;
    logic [BC_W-1:0] cur_len, cur_len1, head_len1;

    // Outputs are held quiet during reset and for one cycle after it.
    assign gate  = csi_clockreset_reset | blk_q;
    assign full  = (cnt_q == CW'(TAG_DEPTH));
    assign empty = (cnt_q == '0);

`ifdef MCB_AVL_MPORT_PRIO_EN
    // Reads compete even when the FIFO is full; a full FIFO parks the winner.
    assign req = avs_sN_read | avs_sN_write;

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int p = int'(NPORT) - 1; p >= 0; p--) begin
            if (req[p]) begin
                win     = PW'(p);
                win_vld = 1'b1;
            end
        end
    end
`else
    // Reads drop out of arbitration while the tag FIFO is full.
    assign req = avs_sN_write | (avs_sN_read & {NPORT{~full}});

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
        return PW'((32'(base) + k) % NPORT);
    endfunction

    // Scan downward so the nearest requester after last_gnt wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned k = NPORT; k >= 1; k--) begin
            if (req[rr_idx(last_gnt_q, k)]) begin
                win     = rr_idx(last_gnt_q, k);
                win_vld = 1'b1;
            end
        end
    end
`endif

    // In IDLE the fresh winner drives the master in the same cycle.
    assign cur      = (state_q == IDLE) ? win : gnt_q;
    assign cur_wr   = avs_sN_write[cur];
    assign cur_rd   = avs_sN_read[cur];
    assign cur_len  = avs_sN_burstcount[cur*BC_W +: BC_W];
    assign cur_len1 = (cur_len == '0) ? BC_W'(1) : cur_len;

    assign avm_m1_address    = avs_sN_address[cur*AVL_A_W +: AVL_A_W];
    assign avm_m1_burstcount = cur_len;
    assign avm_m1_byteenable = avs_sN_byteenable[cur*AVL_BE_W +: AVL_BE_W];
    assign avm_m1_writedata  = avs_sN_writedata[cur*AVL_D_W +: AVL_D_W];

    // Master command qualification; write wins when read and write are both set.
    always_comb begin
        avm_m1_write = 1'b0;
        avm_m1_read  = 1'b0;
        if (!gate) begin
            case (state_q)
                IDLE: begin
                    avm_m1_write = win_vld & cur_wr;
                    avm_m1_read  = win_vld & ~cur_wr & cur_rd & ~full;
                end
                WBURST:  avm_m1_write = cur_wr;
                default: ;
            endcase
        end
    end

    assign mreq = avm_m1_read | avm_m1_write;
    assign acc  = mreq & ~avm_m1_waitrequest;
    assign push = avm_m1_read & ~avm_m1_waitrequest;

    always_comb begin
        avs_sN_waitrequest = '1;
        if (mreq) avs_sN_waitrequest[cur] = avm_m1_waitrequest;
    end

    // Read return routed to the FIFO head port with no added latency.
    assign head_port = tag_port_q[rd_ptr_q];
    assign head_len1 = (tag_len_q[rd_ptr_q] == '0) ? BC_W'(1) : tag_len_q[rd_ptr_q];
    assign rvld      = avm_m1_readdatavalid & ~empty & ~gate;
    assign rlast     = (rbeat_q == head_len1 - BC_W'(1));
    assign pop       = rvld & rlast;

    always_comb begin
        avs_sN_readdatavalid = '0;
        if (rvld) avs_sN_readdatavalid[head_port] = 1'b1;
    end

    assign avs_sN_readdata = avm_m1_readdata;
    assign err_orphan      = err_q;

    // Arbitration FSM, write-burst counter, tag FIFO and read-beat counter.
    always_ff @(posedge csi_clockreset_clk) begin
        if (csi_clockreset_reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= PW'(NPORT - 1);
            wbeat_q    <= '0;
            wlen_q     <= '0;
            rbeat_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            blk_q      <= 1'b1;
        end else begin
            blk_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld && !blk_q) begin
                        gnt_q <= win;
                        if (acc && avm_m1_write) begin
                            if (cur_len1 == BC_W'(1)) begin
                                last_gnt_q <= win;
                            end else begin
                                state_q <= WBURST;
                                wbeat_q <= BC_W'(1);
                                wlen_q  <= cur_len1;
                            end
                        end else if (acc) begin
                            last_gnt_q <= win;
                        end
`ifdef MCB_AVL_MPORT_PRIO_EN
                        else if (cur_rd && !cur_wr && full) begin
                            state_q <= RWAIT;
                        end
`endif
                    end
                end
                WBURST: begin
                    if (acc) begin
                        if (wbeat_q == wlen_q - BC_W'(1)) begin
                            state_q    <= IDLE;
                            last_gnt_q <= gnt_q;
                        end
                        wbeat_q <= wbeat_q + BC_W'(1);
                    end
                end
                RWAIT: begin
                    if (!full) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (push) begin
                tag_port_q[wr_ptr_q] <= cur;
                tag_len_q[wr_ptr_q]  <= cur_len;
                wr_ptr_q             <= wr_ptr_q + TW'(1);
            end
            if (rvld) rbeat_q <= rlast ? '0 : rbeat_q + BC_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + TW'(1);
            if (push != pop) cnt_q <= push ? cnt_q + CW'(1) : cnt_q - CW'(1);
            if (avm_m1_readdatavalid && empty) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mcb_avl_mport.sv
// Scoreboard bench for mcb_avl_mport: stimulus pushes expected master write
// beats and per-port read returns; a negedge monitor pops and compares.
module tb_mcb_avl_mport;

    localparam int unsigned NP  = 2;
    localparam int unsigned AW  = 22;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = 4;
    localparam int unsigned BEW = DW / 8;

    typedef struct { logic [DW-1:0] data; logic [AW-1:0] addr; int cyc; } wexp_t;
    typedef struct { int port; logic [DW-1:0] data; int cyc; } rexp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NP*AW-1:0]  s_addr;
    logic [NP-1:0]     s_rd, s_wr, s_wait, s_rdv;
    logic [NP*BW-1:0]  s_bc;
    logic [NP*BEW-1:0] s_be;
    logic [NP*DW-1:0]  s_wd;
    logic [DW-1:0]     s_rdata;
    logic [AW-1:0]     m_addr;
    logic              m_read, m_write, m_wait, m_rdv, err;
    logic [BW-1:0]     m_bc;
    logic [BEW-1:0]    m_be;
    logic [DW-1:0]     m_wd, m_rd;

    logic [AW-1:0]  p_addr [NP];
    logic           p_rd   [NP];
    logic           p_wr   [NP];
    logic [BW-1:0]  p_bc   [NP];
    logic [BEW-1:0] p_be   [NP];
    logic [DW-1:0]  p_wd   [NP];

    wexp_t wq[$];
    rexp_t rq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int p = 0; p < int'(NP); p++) begin
            s_addr[p*AW +: AW]  = p_addr[p];
            s_rd[p]             = p_rd[p];
            s_wr[p]             = p_wr[p];
            s_bc[p*BW +: BW]    = p_bc[p];
            s_be[p*BEW +: BEW]  = p_be[p];
            s_wd[p*DW +: DW]    = p_wd[p];
        end
    end

    mcb_avl_mport #(.NPORT(NP), .AVL_A_W(AW), .AVL_D_W(DW), .BC_W(BW), .TAG_DEPTH(4)) dut (
        .csi_clockreset_clk   (clk),
        .csi_clockreset_reset (rst),
        .avs_sN_address       (s_addr),
        .avs_sN_read          (s_rd),
        .avs_sN_write         (s_wr),
        .avs_sN_burstcount    (s_bc),
        .avs_sN_byteenable    (s_be),
        .avs_sN_writedata     (s_wd),
        .avs_sN_waitrequest   (s_wait),
        .avs_sN_readdatavalid (s_rdv),
        .avs_sN_readdata      (s_rdata),
        .avm_m1_address       (m_addr),
        .avm_m1_read          (m_read),
        .avm_m1_write         (m_write),
        .avm_m1_burstcount    (m_bc),
        .avm_m1_byteenable    (m_be),
        .avm_m1_writedata     (m_wd),
        .avm_m1_waitrequest   (m_wait),
        .avm_m1_readdatavalid (m_rdv),
        .avm_m1_readdata      (m_rd),
        .err_orphan           (err)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    // Monitor: every accepted master write beat and every slave read return
    // must match the head of its expectation queue, including the cycle.
    always @(negedge clk) begin : mon
        wexp_t we;
        rexp_t re;
        int    rp;
        #2;
        if (m_write && !m_wait) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected got data=%h cyc=%0d required=none", m_wd, cyc);
            end else begin
                we = wq.pop_front();
                if (m_wd !== we.data || m_addr !== we.addr || cyc != we.cyc) begin
                    bad++;
                    $display("FAIL wr_beat got data=%h addr=%h cyc=%0d required data=%h addr=%h cyc=%0d",
                             m_wd, m_addr, cyc, we.data, we.addr, we.cyc);
                end
            end
        end
        if (s_rdv != '0) begin
            total++;
            rp = -1;
            for (int p = 0; p < int'(NP); p++) if (s_rdv[p]) rp = p;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected got rdv=%b data=%h required=none", s_rdv, s_rdata);
            end else begin
                re = rq.pop_front();
                if ($countones(s_rdv) != 1 || rp != re.port || s_rdata !== re.data || cyc != re.cyc) begin
                    bad++;
                    $display("FAIL rd_beat got rdv=%b data=%h cyc=%0d required port=%0d data=%h cyc=%0d",
                             s_rdv, s_rdata, cyc, re.port, re.data, re.cyc);
                end
            end
        end
    end

    task automatic push_w(input logic [DW-1:0] d, input logic [AW-1:0] a, input int c);
        wexp_t e;
        e.data = d; e.addr = a; e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic push_r(input int p, input logic [DW-1:0] d, input int c);
        rexp_t e;
        e.port = p; e.data = d; e.cyc = c;
        rq.push_back(e);
    endtask

    task automatic port_wr(input int p, input logic [AW-1:0] a, input int bc, input int ncmd,
                           input logic [DW-1:0] base);
        bit acc;
        int guard;
        for (int c = 0; c < ncmd; c++) begin
            for (int b = 0; b < bc; b++) begin
                p_addr[p] = a;
                p_bc[p]   = BW'(bc);
                p_be[p]   = '1;
                p_wd[p]   = base + DW'(c * bc + b);
                p_wr[p]   = 1'b1;
                acc = 1'b0;
                guard = 0;
                while (!acc && guard < 100) begin
                    #1 acc = !s_wait[p];
                    @(negedge clk);
                    guard++;
                end
                if (!acc) begin
                    total++; bad++;
                    $display("FAIL wr_timeout port=%0d got=waitrequest_high required=accept", p);
                    p_wr[p] = 1'b0;
                    return;
                end
            end
        end
        p_wr[p] = 1'b0;
    endtask

    task automatic port_rd(input int p, input logic [AW-1:0] a, input int bc, output int acc_cyc);
        bit acc;
        int guard;
        p_addr[p] = a;
        p_bc[p]   = BW'(bc);
        p_be[p]   = '1;
        p_rd[p]   = 1'b1;
        acc = 1'b0;
        guard = 0;
        acc_cyc = -1;
        while (!acc && guard < 100) begin
            #1 acc = !s_wait[p];
            if (acc) acc_cyc = cyc;
            @(negedge clk);
            guard++;
        end
        p_rd[p] = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL rd_timeout port=%0d got=waitrequest_high required=accept", p);
        end
    endtask

    task automatic mbeats(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            m_rdv = 1'b1;
            m_rd  = base + DW'(i);
            @(negedge clk);
        end
        m_rdv = 1'b0;
    endtask

    // Reset with port 0 requesting: slaves stalled and master idle throughout.
    task automatic do_reset();
        rst = 1'b1;
        p_wr[0] = 1'b1;
        p_bc[0] = BW'(1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            #1;
            chk("rst_waitreq", 64'(s_wait), 64'({NP{1'b1}}));
            chk("rst_rdv", 64'(s_rdv), 64'(0));
            chk("rst_mcmd", 64'({m_read, m_write}), 64'(0));
            if (i == 2) begin
                chk("rst_err", 64'(err), 64'(0));
                p_wr[0] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin : main
        int t0, acc5, dummy, guard;
        for (int p = 0; p < int'(NP); p++) begin
            p_addr[p] = '0; p_rd[p] = 1'b0; p_wr[p] = 1'b0;
            p_bc[p] = '0; p_be[p] = '0; p_wd[p] = '0;
        end
        rst = 1'b1; m_wait = 1'b0; m_rdv = 1'b0; m_rd = '0;
        @(negedge clk);

        // Two 4-beat write bursts issued together never interleave.
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 4; i++) push_w(32'h100 + i, 22'h0A0, t0 + i);
        for (int i = 0; i < 4; i++) push_w(32'h200 + i, 22'h1B0, t0 + 4 + i);
        fork
            port_wr(0, 22'h0A0, 4, 1, 32'h100);
            port_wr(1, 22'h1B0, 4, 1, 32'h200);
        join

        // Master stalls beat 2 for 3 cycles; port 1 waits until the burst ends.
        do_reset();
        t0 = cyc;
        push_w(32'h300, 22'h011, t0);
        push_w(32'h301, 22'h011, t0 + 4);
        push_w(32'h302, 22'h011, t0 + 5);
        push_w(32'h303, 22'h011, t0 + 6);
        push_w(32'h400, 22'h022, t0 + 7);
        fork
            port_wr(0, 22'h011, 4, 1, 32'h300);
            port_wr(1, 22'h022, 1, 1, 32'h400);
            begin
                m_wait = 1'b0;
                @(negedge clk);
                m_wait = 1'b1;
                repeat (3) @(negedge clk);
                m_wait = 1'b0;
            end
        join

        // Pipelined reads: 5 return beats split 2 to port 0, 3 to port 1.
        do_reset();
        port_rd(0, 22'h033, 2, dummy);
        port_rd(1, 22'h044, 3, dummy);
        t0 = cyc;
        push_r(0, 32'hA000, t0);
        push_r(0, 32'hA001, t0 + 1);
        push_r(1, 32'hA002, t0 + 2);
        push_r(1, 32'hA003, t0 + 3);
        push_r(1, 32'hA004, t0 + 4);
        mbeats(5, 32'hA000);

        // Full tag FIFO stalls a fifth read until the head burst retires.
        do_reset();
        port_rd(0, 22'h050, 2, dummy);
        port_rd(1, 22'h051, 1, dummy);
        port_rd(0, 22'h052, 1, dummy);
        port_rd(1, 22'h053, 1, dummy);
        t0 = 0;
        fork
            port_rd(0, 22'h054, 1, acc5);
            begin
                repeat (3) @(negedge clk);
                t0 = cyc;
                push_r(0, 32'hB000, t0);
                push_r(0, 32'hB001, t0 + 1);
                mbeats(2, 32'hB000);
            end
        join
        chk("rd5_accept_cyc", 64'(acc5), 64'(t0 + 2));

        // Reset mid read burst; stray beats afterwards are orphans.
        do_reset();
        port_rd(0, 22'h060, 4, dummy);
        t0 = cyc;
        push_r(0, 32'hC000, t0);
        push_r(0, 32'hC001, t0 + 1);
        mbeats(2, 32'hC000);
        chk("err_before", 64'(err), 64'(0));
        do_reset();
        mbeats(2, 32'hD000);
        chk("err_orphan", 64'(err), 64'(1));

        // Continuous single-beat requests from both ports.
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
`ifdef MCB_AVL_MPORT_PRIO_EN
            push_w(32'h500 + i, 22'h070, t0 + i);
`else
            push_w(32'h500 + i, 22'h070, t0 + 2 * i);
            push_w(32'h600 + i, 22'h071, t0 + 2 * i + 1);
`endif
        end
`ifdef MCB_AVL_MPORT_PRIO_EN
        for (int i = 0; i < 4; i++) push_w(32'h600 + i, 22'h071, t0 + 4 + i);
`endif
        fork
            port_wr(0, 22'h070, 1, 4, 32'h500);
            port_wr(1, 22'h071, 1, 4, 32'h600);
        join

        guard = 0;
        while ((wq.size() != 0 || rq.size() != 0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("sb_leftover", 64'(wq.size() + rq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1);
    end

endmodule
